// File: rtl/spram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spram_arb_pkg
//  Purpose  : Shared types and the round-robin pick helper for the SPRAM
//             requester arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package spram_arb_pkg;

    localparam int MAX_REQ = 4;

    typedef logic [1:0] req_id_t;

    // One read-tag slot: valid flag plus the requester that issued the read.
    typedef struct packed {
        logic    vld;
        req_id_t id;
    } rd_tag_t;

    // First set bit strictly after last_grant in circular order. Unused mask
    // bits are zero, so walking all MAX_REQ slots gives the same order as
    // walking only the populated requesters. Scanning from farthest to
    // nearest lets the nearest eligible bit overwrite earlier picks.
    function automatic req_id_t rr_pick(input logic [MAX_REQ-1:0] mask,
                                        input req_id_t            last_grant);
        req_id_t pick;
        req_id_t idx;
        pick = last_grant;
        for (int i = MAX_REQ; i >= 1; i--) begin
            idx = last_grant + req_id_t'(i);
            if (mask[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spram_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : spram_rd_tag_pipe
//  Purpose  : Fixed-depth shift register of read tags that follows each read
//             through the SPRAM latency so the data can be routed back.
//  Revision : 1.0 - initial release
// ============================================================================
module spram_rd_tag_pipe
    import spram_arb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [DEPTH-1:0] r_stage;

    // Shift one slot per cycle; reset drops every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[DEPTH-2:0], tag_in};
        end
    end

    assign tag_out = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/spram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spram_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one single-port SPRAM between
//             NUM_REQ requesters, with read-data return routing and a
//             read-after-write guard.
//  Options  : SPRAM_ARB_STATS_EN adds per-requester 16-bit grant counters.
//  Revision : 1.0 - initial release
// ============================================================================
module spram_rr_arbiter
    import spram_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = 8,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    input  logic [DATA_W-1:0]         mem_dout
`ifdef SPRAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

    localparam int                 c_RAW_W    = $clog2(WRITE_LATENCY + 2);
    localparam logic [c_RAW_W-1:0] c_RAW_LOAD = c_RAW_W'(WRITE_LATENCY + 1);
    localparam int                 c_DEPTH    = READ_LATENCY + 1;

    logic [MAX_REQ-1:0] w_elig;
    logic               w_any;
    req_id_t            w_win;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_din;
    req_id_t            r_last_grant;
    req_id_t            r_issue_id;
    logic [c_RAW_W-1:0] r_raw_cnt;
    rd_tag_t            w_tag_in;
    rd_tag_t            w_tag_out;

    // Eligibility and winner: reads sit out while a recent write may still be
    // invisible; ready is forced low while reset is asserted.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req_valid[i] & (req_we[i] | (r_raw_cnt == '0));
        end
        w_any = rst_n & (|w_elig);
        w_win = rr_pick(w_elig, r_last_grant);
    end

    // One-hot ready to the winner and a mux of the winner's request fields.
    always_comb begin
        req_ready  = '0;
        w_sel_we   = 1'b0;
        w_sel_addr = '0;
        w_sel_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == req_id_t'(i)) begin
                req_ready[i] = w_any;
                w_sel_we     = req_we[i];
                w_sel_addr   = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_din    = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Issue register toward the SPRAM plus round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            r_issue_id   <= '0;
            r_last_grant <= req_id_t'(NUM_REQ - 1);
        end else begin
            mem_en <= w_any;
            mem_we <= w_any & w_sel_we;
            if (w_any) begin
                mem_addr     <= w_sel_addr;
                mem_din      <= w_sel_din;
                r_issue_id   <= w_win;
                r_last_grant <= w_win;
            end
        end
    end

    // Read-after-write guard: reload on every write grant, then count down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw_cnt <= '0;
        end else if (w_any && w_sel_we) begin
            r_raw_cnt <= c_RAW_LOAD;
        end else if (r_raw_cnt != '0) begin
            r_raw_cnt <= r_raw_cnt - 1'b1;
        end
    end

    // The tag enters as the SPRAM samples the read, so its exit lines up with
    // valid mem_dout.
    assign w_tag_in.vld = mem_en & ~mem_we;
    assign w_tag_in.id  = r_issue_id;

    spram_rd_tag_pipe #(
        .DEPTH   (c_DEPTH)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (w_tag_in),
        .tag_out (w_tag_out)
    );

    // Decode the exiting tag into the per-requester response strobe.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_tag_out.id == req_id_t'(i)) begin
                rsp_valid[i] = w_tag_out.vld;
            end
        end
    end

    assign rsp_rdata = mem_dout;

`ifdef SPRAM_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [15:0] r_cnt;

        // Saturating count of handshakes granted to this requester.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (req_valid[g] && req_ready[g] && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end

        assign grant_cnt[g*16 +: 16] = r_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spram_rr_arbiter
//  Purpose  : Directed self-checking bench for spram_rr_arbiter with a
//             behavioural 32 x 8 SPRAM attached to the memory pins.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spram_rr_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int RL      = 2;
    localparam int WL      = 2;

    typedef struct {
        int               edg;
        int               id;
        logic             we;
        logic [ADDR_W-1:0] addr;
    } hs_t;

    typedef struct {
        int               cyc;
        int               id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_din;
    logic [DATA_W-1:0]         mem_dout;
`ifdef SPRAM_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]     grant_cnt;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    hs_t  hs_q[$];
    rsp_t rsp_q[$];

    spram_rr_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
`ifdef SPRAM_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SPRAM: read sampled at edge E is on dout after edge E+RL.
    logic [DATA_W-1:0] mem     [32];
    logic [DATA_W-1:0] rd_pipe [RL+1];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_din;
        rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i <= RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_dout = rd_pipe[RL];

    // Log handshakes (with the edge they complete on) and response pulses.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i])
                hs_q.push_back('{edg: cyc + 1, id: i, we: req_we[i],
                                 addr: req_addr[i*ADDR_W +: ADDR_W]});
            if (rsp_valid[i])
                rsp_q.push_back('{cyc: cyc, id: i, data: rsp_rdata});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_valid[id]                  = 1'b1;
        req_we[id]                     = we;
        req_addr[id*ADDR_W +: ADDR_W]  = a;
        req_wdata[id*DATA_W +: DATA_W] = d;
    endtask

    task automatic clr_req(input int id);
        req_valid[id] = 1'b0;
    endtask

    // Advance until n handshakes are logged; returns just after that edge.
    task automatic wait_hs(input int n, input string tag);
        int t;
        t = 0;
        while (hs_q.size() < n && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (hs_q.size() < n) check(tag, hs_q.size(), n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int last_w;
        int rd_e;
        int rel;
        logic [DATA_W-1:0] exp_d [4];
        int                exp_id[4];
        exp_d[0] = 8'h03; exp_d[1] = 8'h07; exp_d[2] = 8'h03; exp_d[3] = 8'h07;
        exp_id[0] = 0; exp_id[1] = 1; exp_id[2] = 0; exp_id[3] = 1;

        rst_n     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        #2 rst_n  = 1'b0;
        req_valid = 2'b11;

        // Reset state, with requests pending to show ready is held low.
        @(negedge clk);
        check("rst_ready",     req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_mem_en",    mem_en,    1'b0);
        check("rst_mem_we",    mem_we,    1'b0);
        check("rst_mem_addr",  mem_addr,  5'd0);
        check("rst_mem_din",   mem_din,   8'd0);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n     = 1'b1;

        // Fill memory from requester 0, then read address 5 back.
        hs_q.delete(); rsp_q.delete();
        for (int i = 0; i < 32; i++) begin
            set_req(0, 1'b1, ADDR_W'(i), DATA_W'(i));
            wait_hs(i + 1, "fill_timeout");
        end
        clr_req(0);
        check("fill_count", hs_q.size(), 32);
        check("fill_b2b",   hs_q[31].edg - hs_q[0].edg, 31);
        last_w = hs_q[hs_q.size()-1].edg;
        hs_q.delete();
        set_req(0, 1'b0, 5'd5, 8'd0);
        wait_hs(1, "rd5_timeout");
        clr_req(0);
        rd_e = hs_q[0].edg;
        check("rd5_raw_wait", rd_e, last_w + WL + 2);
        repeat (8) @(posedge clk); #1;
        check("rd5_rsp_count", rsp_q.size(), 1);
        check("rd5_rsp_id",    rsp_q[0].id, 0);
        check("rd5_rsp_data",  rsp_q[0].data, 8'h05);
        check("rd5_rsp_cycle", rsp_q[0].cyc, rd_e + RL + 1);

        // Two reads in flight, then a one-cycle reset drops them.
        hs_q.delete(); rsp_q.delete();
        set_req(0, 1'b0, 5'd1, 8'd0);
        set_req(1, 1'b0, 5'd2, 8'd0);
        wait_hs(2, "inflight_timeout");
        rst_n    = 1'b0;
        req_addr = {5'd7, 5'd3};
        hs_q.delete(); rsp_q.delete();
        @(negedge clk);
        check("mid_rst_ready",     req_ready, 2'b00);
        check("mid_rst_rsp_valid", rsp_valid, 2'b00);
        check("mid_rst_mem_en",    mem_en,    1'b0);
        check("mid_rst_mem_we",    mem_we,    1'b0);
        check("mid_rst_mem_addr",  mem_addr,  5'd0);
        check("mid_rst_mem_din",   mem_din,   8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rel   = cyc;

        // Continuous reads from both requesters right after release.
        @(negedge clk);
        check("alt_first_ready", req_ready, 2'b01);
        wait_hs(4, "alt_timeout");
        req_valid = '0;
        check("alt_first_edge", hs_q[0].edg, rel + 1);
        for (int j = 0; j < 4; j++) check($sformatf("alt_grant%0d", j), hs_q[j].id, exp_id[j]);
        repeat (8) @(posedge clk); #1;
        check("alt_rsp_count", rsp_q.size(), 4);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("alt_rsp_id%0d", j),   rsp_q[j].id,   exp_id[j]);
            check($sformatf("alt_rsp_data%0d", j), rsp_q[j].data, exp_d[j]);
            check($sformatf("alt_rsp_cyc%0d", j),  rsp_q[j].cyc,  rel + 1 + j + RL + 1);
        end

        // Simultaneous write (r0) and read (r1) of address 10.
        hs_q.delete(); rsp_q.delete();
        set_req(0, 1'b1, 5'd10, 8'hAA);
        set_req(1, 1'b0, 5'd10, 8'h00);
        wait_hs(1, "raw_wr_timeout");
        clr_req(0);
        wait_hs(2, "raw_rd_timeout");
        clr_req(1);
        check("raw_first_id",  hs_q[0].id, 0);
        check("raw_first_we",  hs_q[0].we, 1'b1);
        check("raw_second_id", hs_q[1].id, 1);
        check("raw_rd_wait",   hs_q[1].edg, hs_q[0].edg + WL + 2);
        repeat (8) @(posedge clk); #1;
        check("raw_rsp_count", rsp_q.size(), 1);
        check("raw_rsp_id",    rsp_q[0].id, 1);
        check("raw_rsp_data",  rsp_q[0].data, 8'hAA);
        check("raw_rsp_cycle", rsp_q[0].cyc, hs_q[1].edg + RL + 1);

        // Back-to-back writes from r1 starve r0's pending read.
        hs_q.delete(); rsp_q.delete();
        set_req(1, 1'b1, 5'd20, 8'h11);
        wait_hs(1, "b2b_w0_timeout");
        set_req(1, 1'b1, 5'd21, 8'h12);
        set_req(0, 1'b0, 5'd21, 8'h00);
        wait_hs(2, "b2b_w1_timeout");
        set_req(1, 1'b1, 5'd22, 8'h13);
        wait_hs(3, "b2b_w2_timeout");
        clr_req(1);
        wait_hs(4, "b2b_rd_timeout");
        clr_req(0);
        check("b2b_ids",     {hs_q[0].id[1:0], hs_q[1].id[1:0], hs_q[2].id[1:0], hs_q[3].id[1:0]},
                             8'b01_01_01_00);
        check("b2b_wr_span", hs_q[2].edg, hs_q[0].edg + 2);
        check("b2b_rd_wait", hs_q[3].edg, hs_q[2].edg + WL + 2);
        repeat (8) @(posedge clk); #1;
        check("b2b_rsp_count", rsp_q.size(), 1);
        check("b2b_rsp_id",    rsp_q[0].id, 0);
        check("b2b_rsp_data",  rsp_q[0].data, 8'h12);

`ifdef SPRAM_ARB_STATS_EN
        // Grant counters: clear on reset, then 5 grants to r0 and 3 to r1.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("stats_reset", grant_cnt, 32'h0);
        hs_q.delete();
        set_req(0, 1'b1, 5'd0, 8'h00);
        wait_hs(5, "stats_r0_timeout");
        clr_req(0);
        set_req(1, 1'b1, 5'd1, 8'h01);
        wait_hs(8, "stats_r1_timeout");
        clr_req(1);
        @(negedge clk);
        check("stats_counts", grant_cnt, {16'd3, 16'd5});
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
